// File: rtl/ras_checkpointed_pkg.sv
// Shared definitions for the checkpointed return address stack.
// Holds the default geometry and the per-cycle stack operation encoding.
package ras_checkpointed_pkg;

  localparam int RAS_DEFAULT_ENTRIES    = 8;
  localparam int RAS_DEFAULT_ADDR_W     = 32;
  localparam int RAS_DEFAULT_CKPT_DEPTH = 8;

  typedef enum logic [1:0] {
    RAS_OP_NONE = 2'd0,
    RAS_OP_PUSH = 2'd1,
    RAS_OP_POP  = 2'd2,
    RAS_OP_SWAP = 2'd3
  } ras_op_e;

  function automatic ras_op_e ras_decode_op(input logic push, input logic pop);
    ras_decode_op = ras_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/ras_checkpointed_sub.sv
// Building blocks for the return address stack: the checkpoint FIFO and
// the single-write, async-read stack storage.
module ras_ckpt_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full
);
  localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign data_out = mem[rd_idx_q];

  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;
    if (do_pop)
      rd_idx_d = (rd_idx_q == IDX_W'(FIFO_DEPTH - 1)) ? '0 : rd_idx_q + 1'b1;
    if (do_push)
      wr_idx_d = (wr_idx_q == IDX_W'(FIFO_DEPTH - 1)) ? '0 : wr_idx_q + 1'b1;
    if (do_push && !do_pop)
      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wr_idx_q] <= data_in;
  end
endmodule

module ras_lutram_1w_1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] ram [DEPTH];

  assign rdata = ram[raddr];

  always_ff @(posedge clk) begin
    if (we)
      ram[waddr] <= wdata;
  end
endmodule

// File: rtl/ras_checkpointed.sv
// Return address stack with saturating occupancy, push/pop swap and a FIFO
// of {ptr, count, top} checkpoints used to repair the stack on mispredicts.
module ras_checkpointed
  import ras_checkpointed_pkg::*;
#(
  parameter int ENTRIES    = RAS_DEFAULT_ENTRIES,
  parameter int ADDR_W     = RAS_DEFAULT_ADDR_W,
  parameter int CKPT_DEPTH = RAS_DEFAULT_CKPT_DEPTH,
  parameter bit REPAIR_TOP = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_addr,
  input  logic                           pop,
  input  logic                           branch_fetched,
  input  logic                           branch_retired,
  input  logic                           fetch_flush,
  input  logic                           early_flush,
  output logic [ADDR_W-1:0]              top_addr,
  output logic                           top_valid,
  output logic [$clog2(ENTRIES+1)-1:0]   count,
  output logic                           ckpt_full
);
  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  typedef struct packed {
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] top;
  } ras_ckpt_t;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ram_we;
  logic [PTR_W-1:0]  ram_waddr;
  logic [ADDR_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_rdata;
  ras_ckpt_t         ckpt_in, ckpt_head;
  logic              ckpt_empty;
  logic              ckpt_rst;
  logic              ckpt_push, ckpt_pop;
  ras_op_e           op;

  assign op        = ras_decode_op(push, pop);
  assign top_addr  = ram_rdata;
  assign top_valid = (count_q != '0);
  assign count     = count_q;

  // Any flush wipes the speculative history; rst keeps priority via the same reset.
  assign ckpt_rst  = rst | fetch_flush | early_flush;
  assign ckpt_push = branch_fetched & ~fetch_flush & ~early_flush;
  assign ckpt_pop  = branch_retired & ~fetch_flush & ~early_flush;
  assign ckpt_in   = '{ptr: ptr_q, count: count_q, top: ram_rdata};

  ras_ckpt_fifo #(
    .DATA_W     ($bits(ras_ckpt_t)),
    .FIFO_DEPTH (CKPT_DEPTH)
  ) u_ckpt_fifo (
    .clk      (clk),
    .rst      (ckpt_rst),
    .push     (ckpt_push),
    .pop      (ckpt_pop),
    .data_in  (ckpt_in),
    .data_out (ckpt_head),
    .empty    (ckpt_empty),
    .full     (ckpt_full)
  );

  ras_lutram_1w_1r #(
    .WIDTH (ADDR_W),
    .DEPTH (ENTRIES)
  ) u_stack (
    .clk   (clk),
    .we    (ram_we & ~rst),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ptr_q),
    .rdata (ram_rdata)
  );

  // Single write port: a flush suppresses push, so repair and push never collide.
  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    ram_we    = 1'b0;
    ram_waddr = ptr_q;
    ram_wdata = push_addr;
    if (fetch_flush) begin
      if (!ckpt_empty) begin
        ptr_d   = ckpt_head.ptr;
        count_d = ckpt_head.count;
        if (REPAIR_TOP) begin
          ram_we    = 1'b1;
          ram_waddr = ckpt_head.ptr;
          ram_wdata = ckpt_head.top;
        end
      end
    end else begin
      case (op)
        RAS_OP_PUSH: begin
          ptr_d     = ptr_q + 1'b1;
          ram_we    = 1'b1;
          ram_waddr = ptr_q + 1'b1;
          if (count_q != CNT_W'(ENTRIES))
            count_d = count_q + 1'b1;
        end
        RAS_OP_POP: begin
          if (count_q != '0) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
          end
        end
        RAS_OP_SWAP: begin
          ram_we = 1'b1;
          if (count_q == '0)
            count_d = CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_ras_checkpointed.sv
// Directed bench for ras_checkpointed with default geometry (8 entries,
// 32-bit addresses, 8 checkpoints, top repair enabled).
module tb_ras_checkpointed;
  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic        branch_fetched;
  logic        branch_retired;
  logic        fetch_flush;
  logic        early_flush;
  logic [31:0] top_addr;
  logic        top_valid;
  logic [3:0]  count;
  logic        ckpt_full;

  int n_cmp = 0;
  int n_bad = 0;

  ras_checkpointed dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .push_addr      (push_addr),
    .pop            (pop),
    .branch_fetched (branch_fetched),
    .branch_retired (branch_retired),
    .fetch_flush    (fetch_flush),
    .early_flush    (early_flush),
    .top_addr       (top_addr),
    .top_valid      (top_valid),
    .count          (count),
    .ckpt_full      (ckpt_full)
  );

  always #5 clk = ~clk;

  // Apply the currently driven inputs for one edge, then return them to idle.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 0; push = 0; pop = 0; branch_fetched = 0; branch_retired = 0;
    fetch_flush = 0; early_flush = 0;
  endtask

  task automatic do_push(input logic [31:0] a);
    push = 1; push_addr = a; step();
  endtask

  task automatic do_pop();
    pop = 1; step();
  endtask

  task automatic do_reset();
    rst = 1; step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (top_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", top_valid); end
    n_cmp++; if (ckpt_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", ckpt_full); end
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_top [3];
    exp_top[0] = 32'h100; exp_top[1] = 32'h200; exp_top[2] = 32'h300;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_push(exp_top[i]);
      n_cmp++; if (top_addr !== exp_top[i]) begin n_bad++; $display("FAIL push_top[%0d]: got %h want %h", i, top_addr, exp_top[i]); end
      n_cmp++; if (count !== 4'(i + 1)) begin n_bad++; $display("FAIL push_count[%0d]: got %0d want %0d", i, count, i + 1); end
    end
    for (int i = 2; i >= 0; i--) begin
      n_cmp++; if (top_addr !== exp_top[i] || top_valid !== 1'b1) begin n_bad++; $display("FAIL pop_top[%0d]: got %h/%b want %h/1", i, top_addr, top_valid, exp_top[i]); end
      do_pop();
      n_cmp++; if (count !== 4'(i)) begin n_bad++; $display("FAIL pop_count[%0d]: got %0d want %0d", i, count, i); end
    end
    do_pop();
    n_cmp++; if (count !== 4'd0 || top_valid !== 1'b0) begin n_bad++; $display("FAIL underflow: got count %0d valid %b want 0/0", count, top_valid); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_push(32'h10 + 32'(i));
      n_cmp++; if (count !== 4'((i + 1 > 8) ? 8 : i + 1)) begin n_bad++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, count, (i + 1 > 8) ? 8 : i + 1); end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (top_addr !== 32'h19 - 32'(i) || top_valid !== 1'b1) begin n_bad++; $display("FAIL sat_pop[%0d]: got %h/%b want %h/1", i, top_addr, top_valid, 32'h19 - 32'(i)); end
      do_pop();
    end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL sat_drain: got %0d want 0", count); end
  endtask

  task automatic test_repair();
    do_reset();
    do_push(32'hA0);
    do_push(32'hB0);
    branch_fetched = 1; step();
    do_pop();
    n_cmp++; if (top_addr !== 32'hA0 || count !== 4'd1) begin n_bad++; $display("FAIL repair_pop: got %h/%0d want a0/1", top_addr, count); end
    do_push(32'hC0);
    n_cmp++; if (top_addr !== 32'hC0 || count !== 4'd2) begin n_bad++; $display("FAIL repair_over: got %h/%0d want c0/2", top_addr, count); end
    // The push alongside the flush must be ignored.
    fetch_flush = 1; push = 1; push_addr = 32'hEE; step();
    n_cmp++; if (top_addr !== 32'hB0) begin n_bad++; $display("FAIL repair_top: got %h want b0", top_addr); end
    n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL repair_count: got %0d want 2", count); end
    n_cmp++; if (ckpt_full !== 1'b0) begin n_bad++; $display("FAIL repair_full: got %b want 0", ckpt_full); end
    // FIFO was cleared: another flush must hold state.
    do_pop();
    fetch_flush = 1; step();
    n_cmp++; if (top_addr !== 32'hA0 || count !== 4'd1) begin n_bad++; $display("FAIL repair_empty: got %h/%0d want a0/1", top_addr, count); end
  endtask

  task automatic test_swap();
    do_push(32'hB1);
    push = 1; pop = 1; push_addr = 32'hDD; step();
    n_cmp++; if (top_addr !== 32'hDD || count !== 4'd2) begin n_bad++; $display("FAIL swap: got %h/%0d want dd/2", top_addr, count); end
    do_pop();
    n_cmp++; if (top_addr !== 32'hA0 || count !== 4'd1) begin n_bad++; $display("FAIL swap_ptr: got %h/%0d want a0/1", top_addr, count); end
    do_reset();
    push = 1; pop = 1; push_addr = 32'h55; step();
    n_cmp++; if (top_addr !== 32'h55 || count !== 4'd1 || top_valid !== 1'b1) begin n_bad++; $display("FAIL swap_empty: got %h/%0d/%b want 55/1/1", top_addr, count, top_valid); end
  endtask

  task automatic test_ckpt_full();
    do_reset();
    do_push(32'h11);
    for (int i = 0; i < 8; i++) begin
      branch_fetched = 1; step();
      n_cmp++; if (ckpt_full !== (i == 7)) begin n_bad++; $display("FAIL fill[%0d]: got %b want %b", i, ckpt_full, i == 7); end
    end
    branch_fetched = 1; step();
    n_cmp++; if (ckpt_full !== 1'b1) begin n_bad++; $display("FAIL extra_fetch: got %b want 1", ckpt_full); end
    branch_fetched = 1; branch_retired = 1; step();
    n_cmp++; if (ckpt_full !== 1'b1) begin n_bad++; $display("FAIL fetch_retire: got %b want 1", ckpt_full); end
    branch_retired = 1; step();
    n_cmp++; if (ckpt_full !== 1'b0) begin n_bad++; $display("FAIL retire: got %b want 0", ckpt_full); end
    branch_fetched = 1; step();
    n_cmp++; if (ckpt_full !== 1'b1) begin n_bad++; $display("FAIL refill: got %b want 1", ckpt_full); end
    early_flush = 1; branch_fetched = 1; push = 1; push_addr = 32'h22; step();
    n_cmp++; if (ckpt_full !== 1'b0) begin n_bad++; $display("FAIL early_flush_full: got %b want 0", ckpt_full); end
    n_cmp++; if (top_addr !== 32'h22 || count !== 4'd2) begin n_bad++; $display("FAIL early_flush_push: got %h/%0d want 22/2", top_addr, count); end
    fetch_flush = 1; step();
    n_cmp++; if (top_addr !== 32'h22 || count !== 4'd2) begin n_bad++; $display("FAIL flush_after_early: got %h/%0d want 22/2", top_addr, count); end
  endtask

  task automatic test_rst_during_flush();
    do_reset();
    do_push(32'h1);
    branch_fetched = 1; step();
    do_push(32'h2);
    rst = 1; fetch_flush = 1; step();
    n_cmp++; if (count !== 4'd0 || top_valid !== 1'b0 || ckpt_full !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %0d/%b/%b want 0/0/0", count, top_valid, ckpt_full); end
    fetch_flush = 1; step();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_discard: got %0d want 0", count); end
  endtask

  initial begin
    rst = 0; push = 0; push_addr = '0; pop = 0; branch_fetched = 0;
    branch_retired = 0; fetch_flush = 0; early_flush = 0;
    test_reset();
    test_push_pop();
    test_saturate();
    test_repair();
    test_swap();
    test_ckpt_full();
    test_rst_during_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ras_checkpointed.md
# ras_checkpointed

Parametrised return address stack for the fetch stage, successor to the basic RAS. It adds configurable address width, depth and checkpoint depth, a saturating occupancy count with an explicit valid flag, and a simultaneous push/pop (coroutine) swap. Each checkpoint stores the stack pointer, the count and, optionally, the top-of-stack value, and restoring a checkpoint repairs that entry. It sits beside the branch predictor: it is fed by fetch decode and repaired by global control flushes.

## Interface
Parameters:
- ENTRIES, 8: stack depth; power of two, ≥2.
- ADDR_W, 32: return address width.
- CKPT_DEPTH, 8: maximum outstanding speculative branches (normally MAX_IDS); power of two.
- REPAIR_TOP, 1: when 1, the checkpoint also stores the top entry, and a restore rewrites it.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- push  in  1  call fetched; push push_addr
- push_addr  in  ADDR_W  return address to push
- pop  in  1  return fetched; pop top
- branch_fetched  in  1  take a checkpoint of the current state
- branch_retired  in  1  release the oldest checkpoint
- fetch_flush  in  1  mispredict; restore from the oldest checkpoint, then clear all checkpoints
- early_flush  in  1  clear all checkpoints without restoring
- top_addr  out  ADDR_W  predicted return address (stack[ptr])
- top_valid  out  1  count > 0
- count  out  $clog2(ENTRIES+1)  live entries, saturating
- ckpt_full  out  1  checkpoint FIFO holds CKPT_DEPTH entries

## Operation
- State: ptr (log2 ENTRIES bits, modulo arithmetic), count, the stack RAM, and the checkpoint FIFO of {ptr, count, top}.
- Priority when several events share a cycle: rst > fetch_flush > early_flush > normal operation.
- Normal operation, push only:
  - ptr+1 (wraps).
  - Write push_addr at ptr+1.
  - count = min(count+1, ENTRIES). When full, the oldest entry is overwritten silently.
- Normal operation, pop only:
  - If count>0: ptr−1 and count−1.
  - If count==0 (underflow): no change, and top_valid stays 0.
- Push and pop together: overwrite stack[ptr] with push_addr. ptr is unchanged. count = max(count,1).
- branch_fetched:
  - Enqueues {ptr, count, stack[ptr]}, captured before that cycle's push/pop.
  - Ignored when ckpt_full, unless branch_retired fires in the same cycle.
  - Upstream must stall fetch on ckpt_full.
- branch_retired: dequeues the oldest checkpoint. Ignored when the FIFO is empty.
- fetch_flush:
  - If the FIFO is non-empty: ptr/count take the oldest checkpoint's values. If REPAIR_TOP, its top is written at its ptr.
  - If the FIFO is empty: ptr/count are held.
  - In both cases the FIFO is cleared, and push/pop/branch_fetched/branch_retired are ignored that cycle.
- early_flush: the FIFO is cleared. Push/pop still apply that cycle. branch_fetched is ignored.
- The stack RAM has a single write port. A repair write and a push never coincide, because a flush blocks push.

## Timing
- top_addr/top_valid/count are combinational from the registered ptr/count via the async-read RAM. Every update is visible the cycle after the triggering edge.
- Push in cycle N → top_addr = push_addr in N+1.
- Restore in cycle N → restored top_addr/count in N+1. The repair write lands on the same edge.
- ckpt_full is registered FIFO state and updates the cycle after an enqueue/dequeue.
- Reset values (ckpt_full is an output, included here): ptr=0, count=0, FIFO empty, top_valid=0, ckpt_full=0. Reset mid-operation discards all checkpoints. RAM contents are not reset, so top_addr is undefined while top_valid=0.

## Structure
- ras_ckpt_t {ptr, count, top} belongs in cva5_types. The count width is derived locally from ENTRIES.
- Sub-modules:
  - Checkpoint FIFO: an instance of cva5_fifo with DATA_TYPE ras_ckpt_t, FIFO_DEPTH=CKPT_DEPTH, rst = rst|fetch_flush|early_flush.
  - Stack: lutram_1w_1r.
- The write-port mux (push vs repair) and the ptr/count next-state logic are local.

## Test plan
- Reset, then 3 pushes (0x100, 0x200, 0x300), then 3 pops → top_addr 0x300, 0x200, 0x100, with count 3→0. A 4th pop underflows: count stays 0, top_valid=0.
- ENTRIES=8, 10 pushes of 0x10..0x19 → count saturates at 8. Eight pops return 0x19..0x12 with top_valid=1 throughout.
- Push 0xA0, 0xB0; checkpoint; pop; push 0xC0 (overwrites 0xB0); fetch_flush → next cycle top_addr=0xB0 (repaired), count=2, ckpt FIFO empty.
- Simultaneous push 0xDD + pop with count=2 → top_addr=0xDD, count=2, ptr unchanged.
- Fill CKPT_DEPTH checkpoints → ckpt_full=1. An extra branch_fetched is dropped, while branch_fetched+branch_retired together keep the FIFO full. early_flush then empties it, and a following fetch_flush leaves ptr/count unchanged.
- Assert rst during a fetch_flush with the FIFO non-empty → next cycle count=0, top_valid=0, ckpt_full=0.
